// File: rtl/sst_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sst_pkg
//  Purpose  : Shared types and default constants for the save-state
//             sequencer (state encoding, snapshot geometry, M2 timing).
//  Revision : 1.0 - initial release
// ============================================================================
package sst_pkg;

    // Default snapshot geometry and timing
    localparam int DEF_SST_REGS = 128;
    localparam int DEF_SETTLE   = 2;
    localparam int DEF_M2_TMO   = 1024;

    // The last register of a snapshot carries the mapper index
    function automatic logic [7:0] sst_idx_addr(input int regs);
        return 8'(regs - 1);
    endfunction

    localparam logic [7:0] SST_IDX_ADDR = sst_idx_addr(DEF_SST_REGS);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_RD_SETTLE = 3'd2,
        ST_RD_PUSH   = 3'd3,
        ST_WR_FETCH  = 3'd4,
        ST_WR_HOLD   = 3'd5,
        ST_FINISH    = 3'd6
    } sst_state_t;

endpackage
`default_nettype wire

// File: rtl/sst_m2_sync.sv
`default_nettype none
// ============================================================================
//  Module   : sst_m2_sync
//  Purpose  : Brings the raw CPU M2 into the clk domain and produces a
//             one-cycle pulse for every falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module sst_m2_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_m2,
    output logic o_fall
);

    // [0],[1] form the synchronizer; [2] is the previous synchronized level
    logic [2:0] r_sh;

    // Shift the raw M2 level through the synchronizer and edge-detect stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh <= 3'b000;
        end else begin
            r_sh <= {r_sh[1:0], i_m2};
        end
    end

    // Held-low reset value means leaving reset never fakes a fall
    assign o_fall = r_sh[2] & ~r_sh[1];

endmodule
`default_nettype wire

// File: rtl/sst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : sst_seq
//  Purpose  : Save-state sequencer, initiator side of the mapper save-state
//             bus. SAVE walks all registers and streams them out; LOAD
//             writes a byte stream back, each write held across an M2 fall.
//  Options  : SST_IDX_CHECK_EN - during LOAD the map-index byte is compared
//             against the live sst_di instead of being written.
//  Revision : 1.0 - initial release
// ============================================================================
module sst_seq
    import sst_pkg::*;
#(
    parameter int SST_REGS = DEF_SST_REGS,
    parameter int SETTLE   = DEF_SETTLE,
    parameter int M2_TMO   = DEF_M2_TMO
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_save,
    input  logic       cmd_load,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       m2,
    output logic       sst_act,
    output logic       sst_we_reg,
    output logic [7:0] sst_addr,
    output logic [7:0] sst_dato,
    input  logic [7:0] sst_di,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);

    localparam logic [7:0]  c_last_addr   = sst_idx_addr(SST_REGS);
    localparam logic [15:0] c_settle_last = 16'(SETTLE - 1);
    localparam logic [15:0] c_tmo_last    = 16'(M2_TMO - 1);
    // A fall seen earlier than this after entering a wait state may belong
    // to a raw edge that happened before act/we_reg were presented
    localparam logic [15:0] c_sync_lat    = 16'd3;
    // Write-hold phases: wait for fall, one extra cycle, we_reg dropped
    localparam logic [1:0]  c_ph_wait     = 2'd0;
    localparam logic [1:0]  c_ph_tail     = 2'd1;
    localparam logic [1:0]  c_ph_drop     = 2'd2;

    sst_state_t  r_state;
    sst_state_t  w_next;
    logic [15:0] r_cnt;
    logic [1:0]  r_ph;
    logic [7:0]  r_addr;
    logic [7:0]  r_dato;
    logic [7:0]  r_tx_data;
    logic        r_err;
    logic        r_load;

    logic w_fall, w_fall_ok, w_tmo;
    logic w_start, w_cnt_clr, w_capture, w_addr_inc, w_latch, w_set_err, w_ph_adv;

    sst_m2_sync u_m2_sync (
        .clk    (clk),
        .rst    (rst),
        .i_m2   (m2),
        .o_fall (w_fall)
    );

    assign w_fall_ok = w_fall && (r_cnt >= c_sync_lat);
    assign w_tmo     = (r_cnt >= c_tmo_last);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and datapath strobes
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_cnt_clr  = 1'b0;
        w_capture  = 1'b0;
        w_addr_inc = 1'b0;
        w_latch    = 1'b0;
        w_set_err  = 1'b0;
        w_ph_adv   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_save || cmd_load) begin
                    w_start = 1'b1;
                    w_next  = ST_ARM;
                end
            end
            ST_ARM: begin
                if (w_fall_ok) begin
                    w_cnt_clr = 1'b1;
                    w_next    = r_load ? ST_WR_FETCH : ST_RD_SETTLE;
                end else if (w_tmo) begin
                    w_set_err = 1'b1;
                    w_next    = ST_FINISH;
                end
            end
            ST_RD_SETTLE: begin
                if (r_cnt == c_settle_last) begin
                    w_capture = 1'b1;
                    w_next    = ST_RD_PUSH;
                end
            end
            ST_RD_PUSH: begin
                if (tx_ready) begin
                    w_cnt_clr = 1'b1;
                    if (r_addr == c_last_addr) begin
                        w_next = ST_FINISH;
                    end else begin
                        w_addr_inc = 1'b1;
                        w_next     = ST_RD_SETTLE;
                    end
                end
            end
            ST_WR_FETCH: begin
                if (rx_valid) begin
                    w_cnt_clr = 1'b1;
`ifdef SST_IDX_CHECK_EN
                    if (r_addr == c_last_addr) begin
                        w_set_err = (rx_data != sst_di);
                        w_next    = ST_FINISH;
                    end else begin
                        w_latch = 1'b1;
                        w_next  = ST_WR_HOLD;
                    end
`else
                    w_latch = 1'b1;
                    w_next  = ST_WR_HOLD;
`endif
                end
            end
            ST_WR_HOLD: begin
                case (r_ph)
                    c_ph_wait: begin
                        if (w_fall_ok) begin
                            w_ph_adv = 1'b1;
                        end else if (w_tmo) begin
                            w_set_err = 1'b1;
                            w_next    = ST_FINISH;
                        end
                    end
                    c_ph_tail: w_ph_adv = 1'b1;
                    default: begin
                        if (r_addr == c_last_addr) begin
                            w_next = ST_FINISH;
                        end else begin
                            w_addr_inc = 1'b1;
                            w_next     = ST_WR_FETCH;
                        end
                    end
                endcase
            end
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Address, data, error, phase and cycle-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= 16'd0;
            r_ph      <= c_ph_wait;
            r_addr    <= 8'd0;
            r_dato    <= 8'd0;
            r_tx_data <= 8'd0;
            r_err     <= 1'b0;
            r_load    <= 1'b0;
        end else begin
            if (w_start) begin
                r_err  <= 1'b0;
                r_addr <= 8'd0;
                r_load <= ~cmd_save;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
            if (w_addr_inc) begin
                r_addr <= r_addr + 8'd1;
            end
            if (w_capture) begin
                r_tx_data <= sst_di;
            end
            if (w_latch) begin
                r_dato <= rx_data;
                r_ph   <= c_ph_wait;
            end else if (w_ph_adv) begin
                r_ph <= r_ph + 2'd1;
            end
            if (w_start || w_cnt_clr) begin
                r_cnt <= 16'd0;
            end else if (r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_FINISH);
    assign sst_act    = busy && !done;
    assign sst_we_reg = (r_state == ST_WR_HOLD) && (r_ph != c_ph_drop);
    assign tx_valid   = (r_state == ST_RD_PUSH);
    assign rx_ready   = (r_state == ST_WR_FETCH);
    assign err        = r_err;
    assign sst_addr   = r_addr;
    assign sst_dato   = r_dato;
    assign tx_data    = r_tx_data;

endmodule
`default_nettype wire
